// File: rtl/regfile_write_buffer.sv
// Write-back buffer in front of the register file write port: a small FIFO drained
// one entry per clock into a registered write stage, with a two-port bypass lookup.
module regfile_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_reg,
  input  logic [31:0]                wb_data,
  output logic                       wb_ready,
  input  logic                       drain_en,
  output logic                       regwrite,
  output logic [4:0]                 write_reg,
  output logic [31:0]                write_data,
  input  logic [4:0]                 read_reg_1,
  input  logic [4:0]                 read_reg_2,
  output logic                       byp_hit1,
  output logic [31:0]                byp_data1,
  output logic                       byp_hit2,
  output logic [31:0]                byp_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_reg_mem  [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_regwrite;
  logic [4:0]    r_write_reg;
  logic [31:0]   r_write_data;

  logic          w_ready;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_rr   [2];
  logic          w_hit  [2];
  logic [31:0]   w_data [2];

  assign w_ready = (r_count != CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Writes to r0 complete the handshake but are dropped here.
  assign w_push  = wb_valid && w_ready && (wb_reg != 5'd0);
  assign w_pop   = drain_en && !w_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_reg_mem[i]  <= '0;
        r_data_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_reg_mem[r_tail]  <= wb_reg;
        r_data_mem[r_tail] <= wb_data;
        r_tail             <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_regwrite   <= 1'b1;
        r_write_reg  <= r_reg_mem[r_head];
        r_write_data <= r_data_mem[r_head];
        r_head       <= r_head + 1'b1;
      end else begin
        r_regwrite <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_rr[0] = read_reg_1;
  assign w_rr[1] = read_reg_2;

  // Scan oldest to youngest so the youngest match overrides; output stage is oldest.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_hit[p]  = 1'b0;
      w_data[p] = '0;
      if (w_rr[p] != 5'd0) begin
        if (r_regwrite && (r_write_reg == w_rr[p])) begin
          w_hit[p]  = 1'b1;
          w_data[p] = r_write_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if ((CW'(i) < r_count) && (r_reg_mem[r_head + AW'(i)] == w_rr[p])) begin
            w_hit[p]  = 1'b1;
            w_data[p] = r_data_mem[r_head + AW'(i)];
          end
        end
      end
    end
  end

  assign wb_ready   = w_ready;
  assign empty      = w_empty;
  assign count      = r_count;
  assign regwrite   = r_regwrite;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign byp_hit1   = w_hit[0];
  assign byp_data1  = w_data[0];
  assign byp_hit2   = w_hit[1];
  assign byp_data2  = w_data[1];

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: reset, single write, r0 drop, full/stall,
// youngest-first bypass, pointer wrap and asynchronous mid-operation reset.
module tb_regfile_write_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic        drain_en = 1'b0;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg_1 = '0;
  logic [4:0]  read_reg_2 = '0;
  logic        byp_hit1;
  logic [31:0] byp_data1;
  logic        byp_hit2;
  logic [31:0] byp_data2;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_err    = 0;

  regfile_write_buffer #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .drain_en   (drain_en),
    .regwrite   (regwrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg_1 (read_reg_1),
    .read_reg_2 (read_reg_2),
    .byp_hit1   (byp_hit1),
    .byp_data1  (byp_data1),
    .byp_hit2   (byp_hit2),
    .byp_data2  (byp_data2),
    .count      (count),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_ready", {31'd0, wb_ready}, 32'd1);
    chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_hit1", {31'd0, byp_hit1}, 32'd0);
    chk("rst_data2", byp_data2, 32'd0);
    #10 reset = 1'b0;

    // Single write {r1, 30}
    drain_en = 1'b1; read_reg_1 = 5'd1;
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'd30;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("sw_count_N", {29'd0, count}, 32'd1);
    chk("sw_regwrite_N", {31'd0, regwrite}, 32'd0);
    chk("sw_hit_N", {31'd0, byp_hit1}, 32'd1);
    chk("sw_bdata_N", byp_data1, 32'd30);
    tick();
    chk("sw_regwrite_N1", {31'd0, regwrite}, 32'd1);
    chk("sw_wreg_N1", {27'd0, write_reg}, 32'd1);
    chk("sw_wdata_N1", write_data, 32'd30);
    chk("sw_count_N1", {29'd0, count}, 32'd0);
    chk("sw_hit_N1", {31'd0, byp_hit1}, 32'd1);
    tick();
    chk("sw_regwrite_N2", {31'd0, regwrite}, 32'd0);
    chk("sw_hit_N2", {31'd0, byp_hit1}, 32'd0);
    chk("sw_bdata_N2", byp_data1, 32'd0);
    chk("sw_wreg_hold", {27'd0, write_reg}, 32'd1);

    // Register 0 is dropped and never hits
    read_reg_1 = 5'd0;
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'd0;
    #1;
    chk("r0_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("r0_count", {29'd0, count}, 32'd0);
    chk("r0_hit", {31'd0, byp_hit1}, 32'd0);
    tick();
    chk("r0_regwrite", {31'd0, regwrite}, 32'd0);

    // Fill r2..r5 while stalled
    drain_en = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      wb_valid = 1'b1; wb_reg = 5'(i); wb_data = 32'(i);
      tick();
    end
    wb_valid = 1'b1; wb_reg = 5'd6; wb_data = 32'd6;
    read_reg_1 = 5'd3;
    #1;
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ready", {31'd0, wb_ready}, 32'd0);
    chk("full_bdata", byp_data1, 32'd3);
    tick();
    chk("full_hold_count", {29'd0, count}, 32'd4);
    chk("full_hold_regwrite", {31'd0, regwrite}, 32'd0);
    drain_en = 1'b1;
    tick();
    chk("drain1_reg", {27'd0, write_reg}, 32'd2);
    chk("drain1_count", {29'd0, count}, 32'd3);
    chk("drain1_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("drain2_reg", {27'd0, write_reg}, 32'd3);
    chk("drain2_count", {29'd0, count}, 32'd3);
    for (int i = 4; i <= 6; i++) begin
      tick();
      chk("drain_rw", {31'd0, regwrite}, 32'd1);
      chk("drain_reg", {27'd0, write_reg}, 32'(i));
      chk("drain_data", write_data, 32'(i));
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);
    tick();
    chk("drain_done_rw", {31'd0, regwrite}, 32'd0);

    // Youngest-first bypass
    drain_en = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hAAAA;
    tick();
    wb_data = 32'hBBBB;
    tick();
    wb_valid = 1'b0;
    read_reg_1 = 5'd7; read_reg_2 = 5'd8;
    #1;
    chk("yb_hit1", {31'd0, byp_hit1}, 32'd1);
    chk("yb_data1", byp_data1, 32'hBBBB);
    chk("yb_hit2", {31'd0, byp_hit2}, 32'd0);
    chk("yb_data2", byp_data2, 32'd0);
    read_reg_2 = 5'd7;
    #1;
    chk("yb_port2", byp_data2, 32'hBBBB);
    drain_en = 1'b1;
    tick();
    chk("yb_pop1_data", write_data, 32'hAAAA);
    chk("yb_pop1_byp", byp_data1, 32'hBBBB);
    tick();
    chk("yb_pop2_data", write_data, 32'hBBBB);
    chk("yb_stage_byp", byp_data1, 32'hBBBB);
    tick();
    chk("yb_gone", {31'd0, byp_hit1}, 32'd0);

    // Wrap-around: 10 back-to-back push/pop pairs
    for (int k = 0; k < 10; k++) begin
      wb_valid = 1'b1; wb_reg = 5'(8 + k); wb_data = 32'(100 + k);
      tick();
      chk("wrap_count", {29'd0, count}, 32'd1);
      if (k > 0) begin
        chk("wrap_reg", {27'd0, write_reg}, 32'(8 + k - 1));
        chk("wrap_data", write_data, 32'(100 + k - 1));
      end
    end
    wb_valid = 1'b0;
    tick();
    chk("wrap_last_rw", {31'd0, regwrite}, 32'd1);
    chk("wrap_last_reg", {27'd0, write_reg}, 32'd17);
    chk("wrap_last_data", write_data, 32'd109);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Asynchronous reset with 3 queued entries and a write in flight
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_reg = 5'(20 + i); wb_data = 32'(200 + i);
      tick();
    end
    wb_valid = 1'b0;
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    read_reg_1 = 5'd21;
    #1;
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    chk("pre_rst_rw", {31'd0, regwrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_rw", {31'd0, regwrite}, 32'd0);
    chk("arst_ready", {31'd0, wb_ready}, 32'd1);
    chk("arst_hit", {31'd0, byp_hit1}, 32'd0);
    chk("arst_wdata", write_data, 32'd0);
    #1 reset = 1'b0;
    drain_en = 1'b1;
    tick();
    chk("post_rst_rw", {31'd0, regwrite}, 32'd0);
    chk("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
